hamming_dec_engine: RTL and testbench
=====================================

// Module: hamming_dec_engine
// PURPOSE
//  Hardware SEC-DED Hamming decoder coprocessor on the data-memory port.
//  On START it reads NUM_WORDS 16-bit codewords from data memory and corrects single errors.
//  It writes 11-bit data plus 2-bit status back, then raises DONE.
//  It consumes the parity-embedded words produced by the encode stage (program 1 format).
//  It offloads program 2 from the core.
// PARAMETERS
//  AW        8   data-memory address width (byte addressed)
//  SRC_BASE  64  byte address of first input codeword (low byte; high byte at +1)
//  DST_BASE  94  byte address of first output word (low byte; high byte at +1)
//  NUM_WORDS 15  codewords processed per START (1..127)
// PORTS
//  CLK          in   1   clock, rising edge
//  RESET_N      in   1   synchronous active-low reset
//  START        in   1   request; sampled only in IDLE
//  DONE         out  1   level; high after completion until next accepted START
//  BUSY         out  1   high in every non-IDLE state
//  MEM_ADDR     out  AW  byte address to data memory
//  MEM_WR_EN    out  1   write strobe, one cycle per byte
//  MEM_WR_DATA  out  8   write byte
//  MEM_RD_DATA  in   8   asynchronous read data for MEM_ADDR, same cycle
//  N_SINGLE     out  8   count of corrected words in last run
//  N_DOUBLE     out  8   count of double-error words in last run
// BEHAVIOUR
//  - Reset (RESET_N=0 at edge): state=IDLE, DONE=0, BUSY=0, MEM_WR_EN=0, MEM_ADDR=0,
//    MEM_WR_DATA=0, N_SINGLE=N_DOUBLE=0, index=0. Reset mid-run aborts the run.
//    No further writes occur; any partially written output is left as is.
//  - FSM: IDLE -> RD_LO -> RD_HI -> WR_LO -> WR_HI -> (RD_LO | FIN) -> IDLE.
//    IDLE: START=1 -> RD_LO; clear DONE, N_SINGLE, N_DOUBLE, index i=0.
//    RD_LO: MEM_ADDR=SRC_BASE+2i; latch cw[7:0].
//    RD_HI: MEM_ADDR=SRC_BASE+2i+1; latch cw[15:8].
//    WR_LO: MEM_ADDR=DST_BASE+2i, MEM_WR_EN=1, data=out[7:0].
//    WR_HI: MEM_ADDR=DST_BASE+2i+1, MEM_WR_EN=1, data=out[15:8].
//      Then i++, with i==NUM_WORDS-1 -> FIN, else RD_LO.
//    FIN: DONE<=1, go IDLE. DONE stays high until a new START is accepted.
//  - Latency: START sampled -> DONE high after 4*NUM_WORDS+1 edges (61 for default).
//  - START while BUSY is ignored. START held high in IDLE with DONE=1 restarts the run.
//  - Address arithmetic is modulo 2^AW; wrap past 255 is legal, not flagged.
//  - Codeword layout: bit k is Hamming position k. Bit0=p0 (overall), 1=p1, 2=p2,
//    3=d1, 4=p4, 7:5=d4..d2, 8=p8, 15:9=d11..d5.
//    syn = XOR of k over set bits k=1..15; P = ^cw[15:0].
//  - Decode is combinational from the latched cw and is registered into MEM_WR_DATA.
//    d = corrected {cw[15:9],cw[7:5],cw[3]}.
//    syn=0,P=0  : no error    -> out={5'b00000,d}
//    P=1        : single; flip bit syn (syn=0 means p0, data unchanged)
//                 -> out={5'b01000,d}; N_SINGLE++
//    syn!=0,P=0 : double      -> out={5'b10000,d_uncorrected}; N_DOUBLE++
//  - Counters saturate at 255. They are held after FIN until the next accepted START.
// TESTING
//  1. Input words all 0x0000 -> every output 0x0000; N_SINGLE=0, N_DOUBLE=0; DONE at edge 61.
//  2. Word0=0x0008 (flip d1) -> out0=0x4000; word1=0xFFFE (flip p0) -> out1=0x47FF; N_SINGLE=2.
//  3. Word0=0x0003 (p0,p1 flipped) -> out0=0x8000, N_DOUBLE=1. Word1=0xFFFF -> out1=0x07FF.
//  4. START pulsed again at cycle 10 of a run -> ignored. DONE still at edge 61.
//     Exactly 30 writes, no write outside DST_BASE..DST_BASE+29.
//  5. RESET_N=0 during WR_HI of word 5 -> next cycle IDLE, DONE=0, MEM_WR_EN=0.
//     A new START gives a full correct run.
//  6. SRC_BASE=250, NUM_WORDS=4 -> reads wrap at 255 to addresses 0..1; outputs correct.

Source files
------------

// File: rtl/hamming_dec_engine.sv
// SEC-DED Hamming decoder coprocessor: reads NUM_WORDS 16-bit codewords from data
// memory, corrects single errors, flags doubles, and writes 11-bit data plus status back.
module hamming_dec_engine #(
    parameter int AW        = 8,
    parameter int SRC_BASE  = 64,
    parameter int DST_BASE  = 94,
    parameter int NUM_WORDS = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    input  logic [7:0]    mem_rd_data,
    output logic [7:0]    n_single,
    output logic [7:0]    n_double
);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        FIN
    } state_t;

    localparam logic [6:0] LAST_IDX = 7'(NUM_WORDS - 1);

    state_t      state;
    state_t      next_state;
    logic [6:0]  idx;
    logic [7:0]  cw_lo;
    logic [7:0]  cw_hi;

    logic [15:0] dec_cw;
    logic [3:0]  syn;
    logic        parity;
    logic        is_single;
    logic        is_double;
    logic [10:0] data_raw;
    logic [10:0] data_fix;
    logic [15:0] dec_out;

    // Byte address of word i (low or high byte), wrapping modulo 2^AW.
    function automatic logic [AW-1:0] word_addr(input int base, input logic [6:0] i,
                                                 input logic hi);
        return AW'(base + 2 * int'(i) + int'(hi));
    endfunction

    // Hamming position of data bit j (d1 at 3, d2..d4 at 5..7, d5..d11 at 9..15).
    function automatic int data_pos(input int j);
        if (j == 0) return 3;
        else if (j < 4) return j + 4;
        else return j + 5;
    endfunction

    // The high byte arrives in RD_HI, so decode the live read data there to have
    // out[7:0] registered in time for WR_LO; WR_LO then decodes the fully latched word.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        dec_cw   = (state == RD_HI) ? {mem_rd_data, cw_lo} : {cw_hi, cw_lo};
        syn      = '0;
        for (int k = 1; k < 16; k++) begin
            if (dec_cw[k]) syn = syn ^ 4'(k);
        end
        parity    = ^dec_cw;
        is_single = parity;
        is_double = !parity && (syn != 4'd0);
        data_raw  = {dec_cw[15:9], dec_cw[7:5], dec_cw[3]};
        data_fix  = data_raw;
        for (int j = 0; j < 11; j++) begin
            data_fix[j] = data_raw[j] ^ (parity && (syn == 4'(data_pos(j))));
        end
        dec_out = {is_double, is_single, 3'b000, (is_double ? data_raw : data_fix)};
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (start) next_state = RD_LO;
            RD_LO:   next_state = RD_HI;
            RD_HI:   next_state = WR_LO;
            WR_LO:   next_state = WR_HI;
            WR_HI:   next_state = (idx == LAST_IDX) ? FIN : RD_LO;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Memory-side outputs are registered: each one is loaded with the value the
    // state being entered must present.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx         <= '0;
            cw_lo       <= '0;
            cw_hi       <= '0;
            done        <= 1'b0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            n_single    <= '0;
            n_double    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        done     <= 1'b0;
                        n_single <= '0;
                        n_double <= '0;
                        mem_addr <= word_addr(SRC_BASE, 7'd0, 1'b0);
                    end
                end
                RD_LO: begin
                    cw_lo    <= mem_rd_data;
                    mem_addr <= word_addr(SRC_BASE, idx, 1'b1);
                end
                RD_HI: begin
                    cw_hi       <= mem_rd_data;
                    mem_wr_data <= dec_out[7:0];
                    mem_wr_en   <= 1'b1;
                    mem_addr    <= word_addr(DST_BASE, idx, 1'b0);
                    if (is_single && n_single != 8'hFF) n_single <= n_single + 8'd1;
                    if (is_double && n_double != 8'hFF) n_double <= n_double + 8'd1;
                end
                WR_LO: begin
                    mem_wr_data <= dec_out[15:8];
                    mem_addr    <= word_addr(DST_BASE, idx, 1'b1);
                end
                WR_HI: begin
                    mem_wr_en <= 1'b0;
                    idx       <= idx + 7'd1;
                    if (idx != LAST_IDX) mem_addr <= word_addr(SRC_BASE, idx + 7'd1, 1'b0);
                end
                FIN: begin
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Self-checking bench for hamming_dec_engine: directed and randomized codeword runs
// compared against a nearest-valid-codeword reference model.
module tb_hamming_dec_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       a_start, b_start;
    logic       a_done, a_busy, a_wr_en, b_done, b_busy, b_wr_en;
    logic [7:0] a_addr, a_wr_data, a_rd, a_ns, a_nd;
    logic [7:0] b_addr, b_wr_data, b_rd, b_ns, b_nd;

    hamming_dec_engine dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .done(a_done), .busy(a_busy),
        .mem_addr(a_addr), .mem_wr_en(a_wr_en), .mem_wr_data(a_wr_data),
        .mem_rd_data(a_rd), .n_single(a_ns), .n_double(a_nd)
    );

    hamming_dec_engine #(.SRC_BASE(250), .NUM_WORDS(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .done(b_done), .busy(b_busy),
        .mem_addr(b_addr), .mem_wr_en(b_wr_en), .mem_wr_data(b_wr_data),
        .mem_rd_data(b_rd), .n_single(b_ns), .n_double(b_nd)
    );

    // Data memories, one per DUT; the bench preloads them through a loader port.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    int         wr_a = 0, bad_a = 0, wr_b = 0, bad_b = 0;
    logic       ld_we = 1'b0, ld_sel = 1'b0;
    logic [7:0] ld_addr = '0, ld_data = '0;

    assign a_rd = mem_a[a_addr];
    assign b_rd = mem_b[b_addr];

    always @(posedge clk) begin
        if (a_wr_en) begin
            mem_a[a_addr] <= a_wr_data;
            wr_a <= wr_a + 1;
            if (a_addr < 8'd94 || a_addr > 8'd123) bad_a <= bad_a + 1;
        end else if (ld_we && !ld_sel) begin
            mem_a[ld_addr] <= ld_data;
        end
        if (b_wr_en) begin
            mem_b[b_addr] <= b_wr_data;
            wr_b <= wr_b + 1;
            if (b_addr < 8'd94 || b_addr > 8'd101) bad_b <= bad_b + 1;
        end else if (ld_we && ld_sel) begin
            mem_b[ld_addr] <= ld_data;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] src_w [16];
    int dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a word is valid if re-encoding its data reproduces it;
    // otherwise look for the unique valid word one bit flip away.
    function automatic logic [10:0] extract(input logic [15:0] cw);
        logic [10:0] d;
        for (int j = 0; j < 11; j++) d[j] = cw[dpos[j]];
        return d;
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] cw = '0;
        for (int j = 0; j < 11; j++) cw[dpos[j]] = d[j];
        for (int p = 1; p < 16; p = p * 2) begin
            logic par = 1'b0;
            for (int k = 1; k < 16; k++) if ((k & p) != 0 && k != p) par ^= cw[k];
            cw[p] = par;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic bit valid(input logic [15:0] cw);
        return encode(extract(cw)) == cw;
    endfunction

    function automatic logic [15:0] ref_decode(input logic [15:0] cw, output int kind);
        kind = 0;
        if (valid(cw)) return {5'b00000, extract(cw)};
        for (int b = 0; b < 16; b++) begin
            logic [15:0] t = cw ^ (16'd1 << b);
            if (valid(t)) begin
                kind = 1;
                return {5'b01000, extract(t)};
            end
        end
        kind = 2;
        return {5'b10000, extract(cw)};
    endfunction

    task automatic load_byte(input bit sel, input logic [7:0] addr, input logic [7:0] data);
        ld_sel  = sel;
        ld_addr = addr;
        ld_data = data;
        ld_we   = 1'b1;
        @(posedge clk);
        #1 ld_we = 1'b0;
    endtask

    task automatic prepare(input bit sel, input int src, input int n);
        for (int i = 0; i < n; i++) begin
            load_byte(sel, 8'(src + 2 * i), src_w[i][7:0]);
            load_byte(sel, 8'(src + 2 * i + 1), src_w[i][15:8]);
        end
        for (int i = 0; i < 2 * n; i++) load_byte(sel, 8'(94 + i), 8'hEE);
    endtask

    task automatic rand_words(input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] cw = encode(11'($urandom));
            int nf = int'($urandom_range(0, 2));
            int b1 = int'($urandom_range(0, 15));
            if (nf >= 1) cw[b1] = ~cw[b1];
            if (nf == 2) begin
                int b2 = (b1 + int'($urandom_range(1, 15))) % 16;
                cw[b2] = ~cw[b2];
            end
            src_w[i] = cw;
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) b_start = v;
        else     a_start = v;
    endtask

    // Start a run, measure edges from the START edge until DONE, check write traffic.
    task automatic run_dut(input bit sel, input int n, input bit pulse_mid);
        int edges = 0;
        int wr0 = sel ? wr_b : wr_a;
        int bad0 = sel ? bad_b : bad_a;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(sel, 1'b0);
        while (!(sel ? b_done : a_done) && edges < 1000) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) check("busy_in_run", 32'(sel ? b_busy : a_busy), 32'd1);
            set_start(sel, pulse_mid && edges == 10);
        end
        check("done_latency", 32'(edges), 32'(4 * n + 1));
        check("write_count", 32'((sel ? wr_b : wr_a) - wr0), 32'(2 * n));
        check("stray_writes", 32'((sel ? bad_b : bad_a) - bad0), 32'd0);
    endtask

    task automatic verify(input bit sel, input int n);
        int ns = 0, nd = 0, kind;
        for (int i = 0; i < n; i++) begin
            logic [15:0] exp = ref_decode(src_w[i], kind);
            logic [15:0] obs = sel ? {mem_b[8'(95 + 2 * i)], mem_b[8'(94 + 2 * i)]}
                                   : {mem_a[8'(95 + 2 * i)], mem_a[8'(94 + 2 * i)]};
            if (kind == 1) ns++;
            if (kind == 2) nd++;
            check($sformatf("out%0d", i), 32'(obs), 32'(exp));
        end
        check("n_single", 32'(sel ? b_ns : a_ns), 32'(ns));
        check("n_double", 32'(sel ? b_nd : a_nd), 32'(nd));
    endtask

    initial begin
        int wr_snap;
        reset_n = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_wr_en", 32'(a_wr_en), 32'd0);
        check("rst_addr", 32'(a_addr), 32'd0);
        check("rst_wr_data", 32'(a_wr_data), 32'd0);
        check("rst_counts", 32'({a_ns, a_nd}), 32'd0);
        reset_n = 1'b1;

        // All-zero codewords decode to all-zero outputs.
        for (int i = 0; i < 16; i++) src_w[i] = 16'h0000;
        prepare(0, 64, 15);
        run_dut(0, 15, 0);
        check("t1_out0", 32'({mem_a[95], mem_a[94]}), 32'h0000);
        verify(0, 15);

        // Single errors in d1 and p0.
        src_w[0] = 16'h0008;
        src_w[1] = 16'hFFFE;
        prepare(0, 64, 15);
        run_dut(0, 15, 0);
        check("t2_out0", 32'({mem_a[95], mem_a[94]}), 32'h4000);
        check("t2_out1", 32'({mem_a[97], mem_a[96]}), 32'h47FF);
        check("t2_nsingle", 32'(a_ns), 32'd2);
        verify(0, 15);

        // Double error, then a clean all-ones word.
        src_w[0] = 16'h0003;
        src_w[1] = 16'hFFFF;
        prepare(0, 64, 15);
        run_dut(0, 15, 0);
        check("t3_out0", 32'({mem_a[95], mem_a[94]}), 32'h8000);
        check("t3_out1", 32'({mem_a[97], mem_a[96]}), 32'h07FF);
        check("t3_ndouble", 32'(a_nd), 32'd1);
        verify(0, 15);

        // Random words with a START pulse mid-run that must be ignored.
        rand_words(15);
        prepare(0, 64, 15);
        run_dut(0, 15, 1);
        verify(0, 15);

        // Reset during WR_HI of word 5, then a clean full run.
        rand_words(15);
        prepare(0, 64, 15);
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_start = 1'b0;
        repeat (23) @(posedge clk);
        @(negedge clk);
        check("t5_wrhi_addr", 32'(a_addr), 32'd105);
        check("t5_wrhi_en", 32'(a_wr_en), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_busy", 32'(a_busy), 32'd0);
        check("t5_done", 32'(a_done), 32'd0);
        check("t5_wr_en", 32'(a_wr_en), 32'd0);
        reset_n = 1'b1;
        wr_snap = wr_a;
        repeat (4) @(negedge clk);
        check("t5_no_writes", 32'(wr_a - wr_snap), 32'd0);
        rand_words(15);
        prepare(0, 64, 15);
        run_dut(0, 15, 0);
        verify(0, 15);

        // Source region wrapping past address 255.
        rand_words(4);
        prepare(1, 250, 4);
        run_dut(1, 4, 0);
        verify(1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
